// File: rtl/freq_mult_exponential.sv
// Frequency multiplier (f*2^n square wave on acc_out) driving an 8-term Horner
// e^x evaluator; each acc_out rising edge is a one-cycle tick on clk.
module freq_mult_exponential (
  input  logic        clk,
  input  logic        rst,
  input  logic        f,
  input  logic        adjust,
  input  logic [2:0]  n,
  output logic        valid,
  output logic        acc_out,
  output logic [7:0]  k,
  input  logic        start,
  input  logic [15:0] x,
  output logic        done,
  output logic [1:0]  intpart,
  output logic [15:0] fracpart
);

  typedef enum logic [1:0] {M_IDLE, M_WAIT1, M_COUNT, M_RUN} mst_t;
  typedef enum logic [1:0] {E_IDLE, E_CALC, E_HOLD} est_t;

  mst_t        mst;
  est_t        est;
  logic [2:0]  f_s;
  logic        f_rise;
  logic [2:0]  n_l;
  logic [7:0]  p, div, pshift, kcalc;
  logic        tick;
  logic [17:0] acc, nacc;
  logic [15:0] xl;
  logic [2:0]  i;
  logic [17:0] phi;
  logic [15:0] prod_unused;

  function automatic logic [17:0] coef(input logic [2:0] idx);
    case (idx)
      3'd0:    coef = 18'd65536;
      3'd1:    coef = 18'd65536;
      3'd2:    coef = 18'd32768;
      3'd3:    coef = 18'd10923;
      3'd4:    coef = 18'd2731;
      3'd5:    coef = 18'd546;
      3'd6:    coef = 18'd91;
      default: coef = 18'd13;
    endcase
  endfunction

  assign f_rise = f_s[1] & ~f_s[2];
  // shift amount reaches 8 for n=7, which empties the 8-bit period; clamp restores k=1
  assign pshift = p >> ({1'b0, n_l} + 4'd1);
  assign kcalc  = (pshift == 8'd0) ? 8'd1 : pshift;
  // tick coincides with the edge that drives acc_out 0->1
  assign tick   = (mst == M_RUN) && !adjust && (div == k - 8'd1) && !acc_out;

  assign {phi, prod_unused} = 34'(acc) * 34'(xl);
  assign nacc = phi + coef(i);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) f_s <= '0;
    else      f_s <= {f_s[1:0], f};
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      mst     <= M_IDLE;
      valid   <= 1'b0;
      acc_out <= 1'b0;
      k       <= '0;
      n_l     <= '0;
      p       <= '0;
      div     <= '0;
    end else if (adjust) begin
      valid   <= 1'b0;
      acc_out <= 1'b0;
      n_l     <= n;
      mst     <= M_WAIT1;
    end else begin
      case (mst)
        M_WAIT1: if (f_rise) begin
          p   <= '0;
          mst <= M_COUNT;
        end
        M_COUNT: if (f_rise) begin
          k     <= kcalc;
          valid <= 1'b1;
          div   <= '0;
          mst   <= M_RUN;
        end else if (p != 8'hff) begin
          p <= p + 8'd1;
        end
        M_RUN: if (div == k - 8'd1) begin
          div     <= '0;
          acc_out <= ~acc_out;
        end else begin
          div <= div + 8'd1;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      est      <= E_IDLE;
      acc      <= '0;
      xl       <= '0;
      i        <= '0;
      done     <= 1'b0;
      intpart  <= '0;
      fracpart <= '0;
    end else if (tick) begin
      case (est)
        E_IDLE: if (start) begin
          xl   <= x;
          acc  <= coef(3'd7);
          i    <= 3'd6;
          done <= 1'b0;
          est  <= E_CALC;
        end
        E_CALC: begin
          acc <= nacc;
          if (i == 3'd0) begin
            intpart  <= nacc[17:16];
            fracpart <= nacc[15:0];
            done     <= 1'b1;
            est      <= E_HOLD;
          end else begin
            i <= i - 3'd1;
          end
        end
        E_HOLD: if (!start) est <= E_IDLE;
        default: est <= E_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_freq_mult_exponential.sv
// Directed bench: reset, k measurement for n=1/0/7, e^x results, latency,
// no-retrigger, adjust pause mid-computation and asynchronous reset mid-CALC.
`timescale 1ns/1ps
module tb_freq_mult_exponential;
  logic        clk = 1'b0, rst = 1'b0, f = 1'b0, adjust = 1'b0, start = 1'b0;
  logic [2:0]  n = '0;
  logic [15:0] x = '0;
  logic        valid, acc_out, done;
  logic [7:0]  k;
  logic [1:0]  intpart;
  logic [15:0] fracpart;
  int          nchk = 0, nerr = 0;

  freq_mult_exponential dut (
    .clk(clk), .rst(rst), .f(f), .adjust(adjust), .n(n),
    .valid(valid), .acc_out(acc_out), .k(k),
    .start(start), .x(x), .done(done), .intpart(intpart), .fracpart(fracpart)
  );

  always #3.333 clk = ~clk;  // ~150 MHz
  always #50    f   = ~f;    // 10 MHz

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nchk++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s: observed %0d expected %0d", tag, got, exp);
    end
  endtask

  // waits (bounded) for the next acc_out rise, sampled on negedge
  task automatic wait_rise(output int cyc);
    bit seen0;
    seen0 = (acc_out == 1'b0);
    cyc = 0;
    while (cyc < 300) begin
      @(negedge clk);
      cyc++;
      if (acc_out == 1'b0) seen0 = 1'b1;
      else if (seen0) return;
    end
    chk("rise_timeout", 0, 1);
  endtask

  task automatic pulse_adjust(input logic [2:0] nv);
    @(negedge clk);
    n = nv; adjust = 1'b1;
    @(negedge clk);
    adjust = 1'b0;
  endtask

  task automatic measure(input logic [2:0] nv, output int wcyc);
    pulse_adjust(nv);
    wcyc = 0;
    while (!valid && wcyc < 200) begin
      @(negedge clk);
      wcyc++;
    end
    chk("valid_up", valid, 1);
  endtask

  task automatic run_exp(input logic [15:0] xv, input int adj_at,
                         input logic [1:0] ei, input logic [15:0] ef, output int cyc);
    int c, first;
    bit stay;
    x = xv; start = 1'b1; first = 0; cyc = 0;
    for (int r = 1; r <= 8; r++) begin
      wait_rise(c);
      cyc += c;
      if (done && first == 0) first = r;
      if (r == adj_at) pulse_adjust(3'd7);
    end
    chk("latency_ticks", first, 8);
    chk("intpart", intpart, ei);
    chk("fracpart", fracpart, ef);
    stay = 1'b1;
    for (int r = 0; r < 6; r++) begin
      wait_rise(c);
      if (!done || fracpart != ef) stay = 1'b0;
    end
    chk("no_retrigger", stay, 1);
    start = 1'b0;
    wait_rise(c);
    wait_rise(c);
    chk("done_held", done, 1);
    chk("frac_held", fracpart, ef);
  endtask

  initial begin
    int w, c, per;
    repeat (5) @(negedge clk);
    chk("rst_valid", valid, 0);
    chk("rst_acc_out", acc_out, 0);
    chk("rst_k", k, 0);
    chk("rst_done", done, 0);
    chk("rst_int", intpart, 0);
    chk("rst_frac", fracpart, 0);
    rst = 1'b1;
    repeat (40) @(negedge clk);
    chk("idle_valid", valid, 0);
    chk("idle_acc_out", acc_out, 0);

    // 15 clk per f period -> P=14 or 15
    measure(3'd1, w);
    chk("n1_valid_time", w <= 50, 1);
    chk("n1_k", k == 8'd3 || k == 8'd4, 1);
    wait_rise(c);
    wait_rise(per);
    chk("n1_period", per, 2 * k);

    measure(3'd0, w);
    chk("n0_k", k == 8'd7 || k == 8'd8, 1);
    wait_rise(c);
    wait_rise(per);
    chk("n0_period", per, 2 * k);

    measure(3'd7, w);
    chk("n7_k", k, 1);
    wait_rise(c);
    wait_rise(per);
    chk("n7_period", per, 2);

    // Horner chains hand-evaluated with truncation after each multiply
    run_exp(16'h8000, 0, 2'd1, 16'd42514, c);
    chk("x8000_fast", c <= 24, 1);
    run_exp(16'h0000, 0, 2'd1, 16'd0, c);
    run_exp(16'h4000, 0, 2'd1, 16'd18613, c);
    run_exp(16'h8000, 3, 2'd1, 16'd42514, c);
    chk("adjust_delays_done", c > 24, 1);

    // asynchronous reset in the middle of a computation
    x = 16'h8000; start = 1'b1;
    wait_rise(c);
    wait_rise(c);
    wait_rise(c);
    #1 rst = 1'b0;
    #1;
    chk("mid_rst_done", done, 0);
    chk("mid_rst_int", intpart, 0);
    chk("mid_rst_frac", fracpart, 0);
    chk("mid_rst_valid", valid, 0);
    chk("mid_rst_k", k, 0);
    start = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    repeat (40) @(negedge clk);
    chk("post_rst_valid", valid, 0);
    chk("post_rst_acc_out", acc_out, 0);

    $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
    $finish;
  end
endmodule

// File: doc/freq_mult_exponential.md
Name: freq_mult_exponential

Overview:
Frequency multiplier plus fixed-point e^x engine on one system clock. The multiplier measures the period of slow input f in clk cycles and generates acc_out, a square wave at roughly f*2^n. Each acc_out rising edge is an internal one-cycle tick that advances an 8-term Horner-form Taylor evaluator of e^x for x in [0,1). The engine runs on clk, gated by that tick; acc_out is never used as a clock.

Parameters:
None. Widths and the 8-term coefficient ROM are fixed.

Ports:
clk  in  1  system clock, rising edge
rst  in  1  asynchronous, active-low reset
f  in  1  asynchronous slow reference input
adjust  in  1  synchronous request to restart measurement; samples n
n  in  3  multiply exponent; target output frequency f*2^n
valid  out  1  high once k is computed and acc_out is running
acc_out  out  1  generated square wave
k  out  8  current half-period of acc_out, in clk cycles
start  in  1  level request to compute e^x
x  in  16  unsigned Q0.16 fraction, x = value/65536
done  out  1  result ready
intpart  out  2  integer part of e^x
fracpart  out  16  fractional part of e^x, Q0.16

Behaviour:
- Reset (rst=0, asynchronous): valid=0, acc_out=0, k=0, done=0, intpart=0, fracpart=0; all FSMs and counters cleared.
- After reset the multiplier is in IDLE, with acc_out held at 0, until adjust is asserted.
- f path: 2-flop synchronizer, then rising-edge detect.
- Multiplier FSM states: IDLE, WAIT1, COUNT, RUN.
  - adjust=1 in any state: valid<=0, acc_out<=0, n latched, next state WAIT1.
  - WAIT1 -> COUNT on the first f rising edge; period counter P cleared.
  - COUNT: P increments every clk, saturating at 255. On the next f rising edge: k<=max(1, P>>(n_latched+1)), valid<=1, divider cleared, next state RUN.
  - RUN: divider counts 0..k-1; on reaching k-1 it wraps to 0 and acc_out toggles. The acc_out period is therefore 2k clk cycles.
- tick: one clk cycle, asserted on the clk edge where acc_out goes 0->1. No tick occurs while valid=0.
- Exponential FSM states: IDLE, CALC, HOLD. It advances only on tick cycles.
  - IDLE: when start=1, latch x, acc<=c7, i<=6, done<=0, next state CALC.
  - CALC: on each tick, acc<=((acc*x)>>16 truncated)+c_i, then i decrements. After c0 is added: intpart<=acc[17:16], fracpart<=acc[15:0], done<=1, next state HOLD.
  - Latency: done rises on the 8th tick, counting the accepting tick as tick 1.
  - HOLD: done and the result stay stable. On a tick with start=0, return to IDLE; done remains 1 until the next start is accepted. Holding start high never retriggers.
- Arithmetic: acc is 18-bit unsigned Q2.16. Product is 34 bits; bits [33:16] are kept.
- Coefficients 1/i! in Q2.16: c0=65536, c1=65536, c2=32768, c3=10923, c4=2731, c5=546, c6=91, c7=13.
- Accuracy: result within ±4 LSB of round(e^x*65536). Overflow is impossible for x<1.
- adjust during CALC: the computation pauses (no ticks) and resumes once valid returns; it is not aborted.
- start or x changes while in CALC are ignored.

Test Plan:
- Reset mid-operation: rst=0 during CALC -> all outputs 0 immediately (asynchronous); after release, valid=0 and acc_out=0 until adjust.
- Multiplier: clk 150 MHz, f 10 MHz, n=1, one-cycle adjust pulse -> valid rises within about 3 f periods; k in {3,4}; acc_out period 2k clk cycles (about 20-25 MHz).
- n=0 and n=7 with the same clocks -> k=7 or 8 for n=0; k=1 (floor clamp) for n=7.
- x=0x8000, start held high for many ticks then low -> after 8 ticks done=1, intpart=1, fracpart=42514±4 (e^0.5); no retrigger while start stays high.
- x=0x0000 -> intpart=1, fracpart=0±4. x=0x4000 -> intpart=1, fracpart=18614±4 (e^0.25).
- adjust pulse during CALC -> done is delayed by the re-measurement time, and the final result is identical to an uninterrupted run.
